decode_ctrl: RTL
================

# decode_ctrl

Decode-stage controller between fetch and execute. Accepts one instruction word and PC per valid/ready handshake, classifies the opcode into the one-hot instruction format, and drives the immediate generator. Presents the decoded bundle to execute through a registered valid/ready interface. Provides flush for branch redirect, and optional skid buffering for full throughput with a registered upstream ready.

## Interface

- `PC_W`, default 32: width of the PC carried alongside the instruction.

- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_flush`  in  1  synchronous flush; discards all held and incoming instructions.
- `i_fetch_valid`  in  1  fetch presents `i_inst` and `i_pc`.
- `o_fetch_ready`  out  1  the block can accept this cycle.
- `i_inst`  in  32  instruction word.
- `i_pc`  in  PC_W  instruction address.
- `o_dec_valid`  out  1  decoded bundle valid.
- `i_dec_ready`  in  1  execute accepts the bundle.
- `o_inst`  out  32  held instruction word.
- `o_pc`  out  PC_W  held PC.
- `o_format`  out  6  one-hot format: [0] R, [1] I, [2] S, [3] B, [4] U, [5] J.
- `o_imm`  out  32  sign-extended immediate for the held instruction.
- `o_illegal`  out  1  held opcode is unrecognised.

## Operation

- **Transfers.** An input transfer occurs when `i_fetch_valid && o_fetch_ready && !i_flush`. An output transfer occurs when `o_dec_valid && i_dec_ready`.
- **Classification at capture.** The format is registered when the instruction is captured:
  - 0110011 → R.
  - 0010011, 0000011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Any other opcode, or `inst[1:0] != 2'b11` → `o_format = 6'b000001` and `o_illegal = 1`.
- **Immediate.** `o_imm` is produced combinationally from the registered `o_inst` and `o_format`, with no path from the fetch inputs. Under R-type it is don't-care, but must equal 0.
- **Main-slot states.**
  - EMPTY → FULL on an input transfer.
  - FULL → EMPTY on an output transfer with no input transfer.
  - FULL → FULL (slot reloaded) on simultaneous output and input transfers.
- **Output stability.** While `o_dec_valid && !i_dec_ready`, all outputs hold bit-stable.
- **Flush.**
  - `i_flush` has priority over all other events.
  - Next cycle: `o_dec_valid = 0` and the skid entry is empty.
  - Any input presented in the flush cycle is dropped.
  - Data registers may keep stale values.
- **Reset values.**
  - `o_dec_valid = 0`, `o_fetch_ready = 1`, `o_illegal = 0`.
  - `o_inst = 0`, `o_pc = 0`, `o_format = 6'b000001`, `o_imm = 0`.
- **Reset mid-operation.** Asserting reset with held entries discards them immediately, without waiting for a clock edge.

## Timing

- Latency: 1 cycle from input transfer to `o_dec_valid`.
- Throughput: 1 instruction per cycle while `i_dec_ready` stays high.
- `o_fetch_ready` depends on configuration (below).
- Valid must never depend combinationally on ready in either direction.

## Configuration

- **With `DECODE_SKID_EN` defined:**
  - A second (skid) entry is added.
  - `o_fetch_ready` is a register, equal to "skid empty".
  - An input arriving while main is FULL and `i_dec_ready = 0` goes into skid, and `o_fetch_ready` falls the next cycle.
  - On the next output transfer, skid moves to main; `o_fetch_ready` rises the next cycle.
  - Skid contents are already classified.
  - Ordering is strictly FIFO.
- **Without the macro:**
  - Single entry only.
  - `o_fetch_ready = !o_dec_valid || i_dec_ready`, combinational.

## Structure

- Package `decode_pkg` holds:
  - opcode localparams;
  - one-hot format constants (`FMT_R` … `FMT_J`);
  - the `classify(opcode)` function returning {illegal, format}.
- One sub-module: the existing `imm` immediate generator, instantiated once on the main-slot registers.
- The controller itself is a single always_ff block plus ready/valid logic.

## Test plan

- **Single I-type.** Reset, then present `0xFFF00093` (addi x1,x0,-1) at `pc = 0x100` with `i_dec_ready = 1` → next cycle: `o_dec_valid = 1`, `o_format = 6'b000010`, `o_imm = 0xFFFFFFFF`, `o_pc = 0x100`.
- **Back-to-back formats.** Feed `0x00812423` (sw), `0xFE000EE3` (beq −4), `0x000012B7` (lui), `0x0080006F` (jal +8) back-to-back → one output per cycle; immediates in order: `0x8`, `0xFFFFFFFC`, `0x00001000`, `0x8`.
- **Stall (skid build).** Hold `i_dec_ready = 0` for 3 cycles while fetch streams → outputs stable. With `DECODE_SKID_EN`: the second instruction is held in skid, and `o_fetch_ready = 0` from the following cycle. On release, the three instructions emerge in order with no loss or duplication.
- **Flush.** Assert `i_flush` with both entries full and a new input present → next cycle: `o_dec_valid = 0`, the dropped input never appears, and `o_fetch_ready = 1`.
- **Illegal opcode.** Present `0x00000000` → `o_illegal = 1`, `o_format = 6'b000001`, `o_imm = 0`.
- **Reset mid-operation.** Assert `i_rst` between clock edges with `o_dec_valid = 1` → `o_dec_valid` drops immediately, and all outputs take their reset values.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, one-hot instruction formats, slot state,
// and the opcode classifier used at capture time.
package decode_pkg;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [5:0] FMT_R = 6'b000001;
  localparam logic [5:0] FMT_I = 6'b000010;
  localparam logic [5:0] FMT_S = 6'b000100;
  localparam logic [5:0] FMT_B = 6'b001000;
  localparam logic [5:0] FMT_U = 6'b010000;
  localparam logic [5:0] FMT_J = 6'b100000;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  typedef struct packed {
    logic       illegal;
    logic [5:0] fmt;
  } cls_t;

  // Every legal opcode ends in 2'b11, so a compressed/invalid low pair falls to default.
  function automatic cls_t classify(input logic [6:0] opcode);
    cls_t c;
    c.illegal = 1'b0;
    c.fmt     = FMT_R;
    case (opcode)
      OP_OP:                               c.fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: c.fmt = FMT_I;
      OP_STORE:                            c.fmt = FMT_S;
      OP_BRANCH:                           c.fmt = FMT_B;
      OP_LUI, OP_AUIPC:                    c.fmt = FMT_U;
      OP_JAL:                              c.fmt = FMT_J;
      default:                             c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_imm.sv
// Immediate generator: sign-extended immediate from an instruction word and its
// one-hot format. R-type (and therefore illegal) instructions yield zero.
module imm
  import decode_pkg::*;
(
  input  logic [31:0] i_inst,
  input  logic [5:0]  i_format,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = '0;
    case (i_format)
      FMT_I: o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      FMT_S: o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      FMT_B: o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                      i_inst[11:8], 1'b0};
      FMT_U: o_imm = {i_inst[31:12], 12'b0};
      FMT_J: o_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                      i_inst[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller: captures fetch words, classifies them, and presents a
// registered bundle to execute. Define DECODE_SKID_EN for a second skid entry.
module decode_ctrl
  import decode_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_fetch_valid,
  output logic            o_fetch_ready,
  input  logic [31:0]     i_inst,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_dec_valid,
  input  logic            i_dec_ready,
  output logic [31:0]     o_inst,
  output logic [PC_W-1:0] o_pc,
  output logic [5:0]      o_format,
  output logic [31:0]     o_imm,
  output logic            o_illegal
);

  slot_e           r_state;
  slot_e           w_state_nxt;
  logic [31:0]     r_inst;
  logic [PC_W-1:0] r_pc;
  logic [5:0]      r_fmt;
  logic            r_ill;
  cls_t            w_in_cls;
  logic            w_in_xfer;
  logic            w_out_xfer;
  logic            w_load_main;

`ifdef DECODE_SKID_EN
  logic            r_sk_valid;
  logic            w_sk_valid_nxt;
  logic            w_load_skid;
  logic            w_main_from_skid;
  logic [31:0]     r_sk_inst;
  logic [PC_W-1:0] r_sk_pc;
  logic [5:0]      r_sk_fmt;
  logic            r_sk_ill;

  assign o_fetch_ready = !r_sk_valid;

  // Main refills from skid before fetch; skid is only ever occupied while main is full.
  always_comb begin
    w_in_cls         = classify(i_inst[6:0]);
    w_in_xfer        = i_fetch_valid && o_fetch_ready && !i_flush;
    w_out_xfer       = (r_state == SLOT_FULL) && i_dec_ready;
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    w_sk_valid_nxt   = r_sk_valid;
    if (i_flush) begin
      w_state_nxt    = SLOT_EMPTY;
      w_sk_valid_nxt = 1'b0;
    end else if ((r_state == SLOT_EMPTY) || w_out_xfer) begin
      if (r_sk_valid) begin
        w_main_from_skid = 1'b1;
        w_sk_valid_nxt   = 1'b0;
        w_state_nxt      = SLOT_FULL;
      end else if (w_in_xfer) begin
        w_load_main = 1'b1;
        w_state_nxt = SLOT_FULL;
      end else begin
        w_state_nxt = SLOT_EMPTY;
      end
    end else if (w_in_xfer) begin
      w_load_skid    = 1'b1;
      w_sk_valid_nxt = 1'b1;
    end
  end
`else
  assign o_fetch_ready = !o_dec_valid || i_dec_ready;

  always_comb begin
    w_in_cls    = classify(i_inst[6:0]);
    w_in_xfer   = i_fetch_valid && o_fetch_ready && !i_flush;
    w_out_xfer  = (r_state == SLOT_FULL) && i_dec_ready;
    w_state_nxt = r_state;
    w_load_main = 1'b0;
    if (i_flush) begin
      w_state_nxt = SLOT_EMPTY;
    end else if ((r_state == SLOT_EMPTY) || w_out_xfer) begin
      if (w_in_xfer) begin
        w_load_main = 1'b1;
        w_state_nxt = SLOT_FULL;
      end else begin
        w_state_nxt = SLOT_EMPTY;
      end
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= SLOT_EMPTY;
      r_inst  <= '0;
      r_pc    <= '0;
      r_fmt   <= FMT_R;
      r_ill   <= 1'b0;
`ifdef DECODE_SKID_EN
      r_sk_valid <= 1'b0;
      r_sk_inst  <= '0;
      r_sk_pc    <= '0;
      r_sk_fmt   <= FMT_R;
      r_sk_ill   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main) begin
        r_inst <= i_inst;
        r_pc   <= i_pc;
        r_fmt  <= w_in_cls.fmt;
        r_ill  <= w_in_cls.illegal;
      end
`ifdef DECODE_SKID_EN
      else if (w_main_from_skid) begin
        r_inst <= r_sk_inst;
        r_pc   <= r_sk_pc;
        r_fmt  <= r_sk_fmt;
        r_ill  <= r_sk_ill;
      end
      r_sk_valid <= w_sk_valid_nxt;
      if (w_load_skid) begin
        r_sk_inst <= i_inst;
        r_sk_pc   <= i_pc;
        r_sk_fmt  <= w_in_cls.fmt;
        r_sk_ill  <= w_in_cls.illegal;
      end
`endif
    end
  end

  assign o_dec_valid = (r_state == SLOT_FULL);
  assign o_inst      = r_inst;
  assign o_pc        = r_pc;
  assign o_format    = r_fmt;
  assign o_illegal   = r_ill;

  imm u_imm (
    .i_inst   (r_inst),
    .i_format (r_fmt),
    .o_imm    (o_imm)
  );

endmodule
